aud_dsp_player: RTL and testbench
=================================

Name: aud_dsp_player

Overview:
Parametrised next-generation playback DSP. It walks a programmable SRAM region one sample per DACLRCK frame and drives signed PCM to the DAC interface. Supported modes:
- fast (stride)
- slow-hold (sample repeat)
- slow-interpolate (linear)

Over the previous generation it adds forward or reverse play, loop or one-shot, and runtime region bounds. It sits between the SRAM reader and the I2S/DAC serializer.

Parameters:
DATA_W, 16, sample width (signed two's complement)
ADDR_W, 20, SRAM word address width
SPD_W, 4, speed factor width; factor S = i_speed, with 0 treated as 1

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous active-high reset
i_start  in  1  level; start from IDLE, resume from PAUSE
i_pause  in  1  level; pause playback
i_stop  in  1  level; abort to IDLE
i_mode  in  2  00 fast, 01 slow-hold, 10 slow-interp, 11 = fast
i_speed  in  SPD_W  speed factor S
i_reverse  in  1  1 = addresses decrement
i_loop  in  1  1 = wrap at region boundary, 0 = one-shot
i_region_start  in  ADDR_W  first address of clip (inclusive)
i_region_end  in  ADDR_W  last address of clip (inclusive)
i_daclrck  in  1  DAC left/right clock, already synchronous to i_clk
i_sram_data  in  DATA_W  signed data at o_sram_addr, valid the cycle after the address changes
o_sram_addr  out  ADDR_W  read address
o_dac_data  out  DATA_W  signed sample to DAC
o_playing  out  1  high in PROCESS/WAIT_LOW/WAIT_HIGH
o_done  out  1  one-cycle pulse when one-shot clip ends

Behaviour:
- Reset (i_rst high at posedge): state=IDLE; o_sram_addr=0; o_dac_data=0; counter k=0; prev=0; latched region=0/0; o_playing=0; o_done=0. Reset mid-play behaves identically, with no partial sample emitted.
- States: IDLE, PROCESS, WAIT_LOW, WAIT_HIGH, PAUSE.
- Command priority, all states: i_stop > i_pause > i_start.
- IDLE:
  - o_dac_data=0.
  - On i_start with i_region_start <= i_region_end: latch start, end, reverse and loop; set addr = start (forward) or end (reverse); k=0; go to WAIT_LOW.
  - Invalid region: ignore i_start.
- WAIT_LOW: wait for i_daclrck=1, then go to WAIT_HIGH.
- WAIT_HIGH: wait for i_daclrck=0, then go to PROCESS. PROCESS therefore executes once per frame, on the falling edge.
- PROCESS is a single cycle that computes o_dac_data and the next address from the current i_sram_data, then goes to WAIT_LOW.
- Mode and speed are sampled each PROCESS. If k >= S, k is reset to 0 before use.
- Step direction: d=+1, or -1 if reversed.
- Fast mode: out = i_sram_data; addr += d*S; k stays 0.
- Slow-hold mode: out = i_sram_data; if k==S-1 then addr += d and k=0, else k++.
- Slow-interp mode:
  - k==0: out = i_sram_data; prev = i_sram_data; addr += d.
  - k>0: out = (prev*(S-k) + i_sram_data*k) / S.
  - k = (k==S-1) ? 0 : k+1.
- Interp arithmetic:
  - Products use DATA_W+SPD_W+1 bits and the sum uses DATA_W+SPD_W+2 bits, both signed, with no overflow.
  - Division is signed and truncates toward zero.
  - The result always lies between prev and the current sample, so it fits DATA_W without saturation.
- Boundary rule: compute the candidate address in ADDR_W+1 bits. The region is out of range when the candidate > end (forward) or < start (reverse, including underflow).
  - Loop=1: addr = start (forward) or end (reverse); k=0.
  - Loop=0: o_done pulses for one cycle; go to IDLE; o_dac_data=0 from the next cycle.
- PAUSE:
  - o_dac_data=0; addr, k and prev are held.
  - i_start resumes to WAIT_LOW; i_stop goes to IDLE.
- Pause or stop seen in WAIT_LOW/WAIT_HIGH/PROCESS takes effect next cycle. PROCESS still completes its own update that cycle.
- Region, reverse and loop inputs are ignored after start until the next IDLE->start.

Test Plan:
- Fast, forward, one-shot: region 100..109, S=3. Addresses 100, 103, 106, 109; the next step gives o_done one pulse and o_dac_data=0 in IDLE.
- Slow-hold, reverse, loop: region 10..12, S=2. Address sequence per frame is 12,12,11,11,10,10,12,12; o_done stays 0.
- Slow-interp: S=4, samples x[n]=-400, x[n+1]=400. Outputs -400, -200, 0, 200, then 400.
- Pause after 5 frames for 10 frames, then resume. o_dac_data=0 while paused, and playback resumes at the held address and k.
- Simultaneous i_stop and i_pause in WAIT_HIGH: state goes to IDLE, not PAUSE. i_start with region start 50 > end 40 leaves the block in IDLE.
- Assert i_rst mid-interpolation: all outputs read zero the next cycle and the state is IDLE.

Source files
------------

// File: rtl/aud_dsp_player.sv
// Playback DSP: walks a latched SRAM region once per DACLRCK frame and emits
// signed PCM in fast (stride), slow-hold (repeat) or slow-interpolate mode.
module aud_dsp_player #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20,
  parameter int SPD_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic [1:0]        i_mode,
  input  logic [SPD_W-1:0]  i_speed,
  input  logic              i_reverse,
  input  logic              i_loop,
  input  logic [ADDR_W-1:0] i_region_start,
  input  logic [ADDR_W-1:0] i_region_end,
  input  logic              i_daclrck,
  input  logic [DATA_W-1:0] i_sram_data,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_dac_data,
  output logic              o_playing,
  output logic              o_done
);

  localparam int PW  = DATA_W + SPD_W + 1;
  localparam int SW  = DATA_W + SPD_W + 2;
  localparam int AW1 = ADDR_W + 1;
  localparam logic [SPD_W-1:0] ONE_S = SPD_W'(1);

  typedef enum logic [2:0] {IDLE, PROCESS, WAIT_LOW, WAIT_HIGH, PAUSE} state_t;

  state_t                   state;
  logic [ADDR_W-1:0]        addr;
  logic [ADDR_W-1:0]        reg_start;
  logic [ADDR_W-1:0]        reg_end;
  logic                     rev;
  logic                     loop_en;
  logic [SPD_W-1:0]         k;
  logic signed [DATA_W-1:0] prev;
  logic signed [DATA_W-1:0] dac;

  logic [SPD_W-1:0]         s_val;
  logic [SPD_W-1:0]         k_eff;
  logic [SPD_W-1:0]         k_nxt;
  logic signed [DATA_W-1:0] cur;
  logic signed [DATA_W-1:0] out_val;
  logic                     move;
  logic                     take_prev;
  logic [ADDR_W:0]          step;
  logic [ADDR_W:0]          cand;
  logic                     oob;

  // Weighted blend of prev and cur at phase kk of s; exact products and sum,
  // quotient truncates toward zero and always lands between the two samples.
  function automatic logic signed [DATA_W-1:0] interp(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic [SPD_W-1:0]         s,
    input logic [SPD_W-1:0]         kk
  );
    logic signed [SPD_W:0] wa;
    logic signed [SPD_W:0] wb;
    logic signed [SPD_W:0] ws;
    logic signed [PW-1:0]  pa;
    logic signed [PW-1:0]  pb;
    logic signed [SW-1:0]  sum;
    logic signed [SW-1:0]  q;
    wa  = $signed({1'b0, s - kk});
    wb  = $signed({1'b0, kk});
    ws  = $signed({1'b0, s});
    pa  = PW'(a) * PW'(wa);
    pb  = PW'(b) * PW'(wb);
    sum = SW'(pa) + SW'(pb);
    q   = sum / SW'(ws);
    return q[DATA_W-1:0];
  endfunction

  always_comb begin
    s_val     = (i_speed == '0) ? ONE_S : i_speed;
    k_eff     = (k >= s_val) ? '0 : k;
    cur       = $signed(i_sram_data);
    out_val   = cur;
    move      = 1'b0;
    take_prev = 1'b0;
    k_nxt     = '0;
    step      = AW1'(1);
    case (i_mode)
      2'b01: begin
        if (k_eff == s_val - ONE_S) move = 1'b1;
        else                        k_nxt = k_eff + ONE_S;
      end
      2'b10: begin
        if (k_eff == '0) begin
          move      = 1'b1;
          take_prev = 1'b1;
        end else begin
          out_val = interp(prev, cur, s_val, k_eff);
        end
        k_nxt = (k_eff == s_val - ONE_S) ? '0 : k_eff + ONE_S;
      end
      default: begin
        move = 1'b1;
        step = AW1'(s_val);
      end
    endcase
    // Extra top bit catches both overflow past end and underflow below zero.
    cand = rev ? ({1'b0, addr} - step) : ({1'b0, addr} + step);
    oob  = rev ? (cand[ADDR_W] || (cand < {1'b0, reg_start}))
               : (cand > {1'b0, reg_end});
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      addr      <= '0;
      dac       <= '0;
      k         <= '0;
      prev      <= '0;
      reg_start <= '0;
      reg_end   <= '0;
      rev       <= 1'b0;
      loop_en   <= 1'b0;
      o_playing <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          dac       <= '0;
          o_playing <= 1'b0;
          if (!i_stop && !i_pause && i_start && (i_region_start <= i_region_end)) begin
            reg_start <= i_region_start;
            reg_end   <= i_region_end;
            rev       <= i_reverse;
            loop_en   <= i_loop;
            addr      <= i_reverse ? i_region_end : i_region_start;
            k         <= '0;
            state     <= WAIT_LOW;
            o_playing <= 1'b1;
          end
        end
        WAIT_LOW, WAIT_HIGH: begin
          if (i_stop) begin
            state     <= IDLE;
            o_playing <= 1'b0;
          end else if (i_pause) begin
            state     <= PAUSE;
            o_playing <= 1'b0;
          end else if ((state == WAIT_LOW) && i_daclrck) begin
            state <= WAIT_HIGH;
          end else if ((state == WAIT_HIGH) && !i_daclrck) begin
            state <= PROCESS;
          end
        end
        PROCESS: begin
          dac <= out_val;
          k   <= k_nxt;
          if (take_prev) prev <= cur;
          if (move) begin
            if (!oob) begin
              addr <= cand[ADDR_W-1:0];
            end else if (loop_en) begin
              addr <= rev ? reg_end : reg_start;
              k    <= '0;
            end else begin
              o_done <= 1'b1;
            end
          end
          if (i_stop || (move && oob && !loop_en)) begin
            state     <= IDLE;
            o_playing <= 1'b0;
          end else if (i_pause) begin
            state     <= PAUSE;
            o_playing <= 1'b0;
          end else begin
            state <= WAIT_LOW;
          end
        end
        PAUSE: begin
          dac <= '0;
          if (i_stop) begin
            state <= IDLE;
          end else if (!i_pause && i_start) begin
            state     <= WAIT_LOW;
            o_playing <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          o_playing <= 1'b0;
        end
      endcase
    end
  end

  assign o_sram_addr = addr;
  assign o_dac_data  = dac;

endmodule

// File: tb/tb_aud_dsp_player.sv
// Directed bench for aud_dsp_player: registered SRAM model, DACLRCK frames,
// hand-computed address and sample expectations.
module tb_aud_dsp_player;
  localparam int DW = 16;
  localparam int AW = 20;
  localparam int SW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, pause, stop, reverse, loop_i, daclrck;
  logic [1:0]        mode;
  logic [SW-1:0]     speed;
  logic [AW-1:0]     rs, re;
  logic signed [DW-1:0] sram_q;
  logic [AW-1:0]     addr;
  logic signed [DW-1:0] dac;
  logic              playing, done;

  logic signed [DW-1:0] mem [256];

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int done_dat = 0;
  int base;

  aud_dsp_player #(.DATA_W(DW), .ADDR_W(AW), .SPD_W(SW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_pause(pause), .i_stop(stop),
    .i_mode(mode), .i_speed(speed), .i_reverse(reverse), .i_loop(loop_i),
    .i_region_start(rs), .i_region_end(re), .i_daclrck(daclrck),
    .i_sram_data(sram_q), .o_sram_addr(addr), .o_dac_data(dac),
    .o_playing(playing), .o_done(done)
  );

  // SRAM returns data the cycle after the address changes
  always @(posedge clk) sram_q <= mem[addr[7:0]];

  always @(negedge clk) begin
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_dat <= int'(dac);
    end
  end

  task automatic chk_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic frame();
    daclrck = 1'b1;
    repeat (3) @(negedge clk);
    daclrck = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic go(input logic [1:0] m, input int s, input int rv, input int lp,
                    input int a0, input int a1);
    mode    = m;
    speed   = SW'(s);
    reverse = (rv != 0);
    loop_i  = (lp != 0);
    rs      = AW'(a0);
    re      = AW'(a1);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int a1 [4] = '{100, 103, 106, 109};
    int d1 [4] = '{0, 30, 60, 90};
    int a2 [8] = '{12, 12, 11, 11, 10, 10, 12, 12};
    int d2 [8] = '{-880, -880, -890, -890, -900, -900, -880, -880};
    int d3 [5] = '{-400, -200, 0, 200, 400};
    int a4 [5] = '{30, 30, 30, 31, 31};
    int d4 [5] = '{-700, -700, -700, -690, -690};

    for (int i = 0; i < 256; i++) mem[i] = DW'(i * 10 - 1000);
    start = 0; pause = 0; stop = 0; reverse = 0; loop_i = 0; daclrck = 0;
    mode = 2'b00; speed = '0; rs = '0; re = '0;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_eq("rst_dac", int'(dac), 0);
    chk_eq("rst_addr", int'(addr), 0);
    chk_eq("rst_playing", int'(playing), 0);
    chk_eq("rst_done", int'(done), 0);
    rst = 1'b0;
    @(negedge clk);

    // fast, forward, one-shot, stride 3
    base = done_cnt;
    go(2'b00, 3, 0, 0, 100, 109);
    chk_eq("fast_start_addr", int'(addr), 100);
    chk_eq("fast_playing", int'(playing), 1);
    for (int f = 0; f < 4; f++) begin
      chk_eq("fast_addr", int'(addr), a1[f]);
      frame();
      if (f < 3) chk_eq("fast_dat", int'(dac), d1[f]);
    end
    chk_eq("fast_done_pulses", done_cnt - base, 1);
    chk_eq("fast_last_dat", done_dat, 90);
    chk_eq("fast_end_playing", int'(playing), 0);
    chk_eq("fast_end_dac", int'(dac), 0);

    // slow-hold, reverse, loop
    base = done_cnt;
    go(2'b01, 2, 1, 1, 10, 12);
    for (int f = 0; f < 8; f++) begin
      chk_eq("hold_addr", int'(addr), a2[f]);
      frame();
      chk_eq("hold_dat", int'(dac), d2[f]);
    end
    chk_eq("hold_no_done", done_cnt - base, 0);
    chk_eq("hold_playing", int'(playing), 1);
    halt();
    chk_eq("hold_stop_playing", int'(playing), 0);

    // slow-interp between -400 and 400, S=4
    mem[20] = -16'sd400;
    mem[21] = 16'sd400;
    go(2'b10, 4, 0, 0, 20, 30);
    for (int f = 0; f < 5; f++) begin
      frame();
      chk_eq("interp_dat", int'(dac), d3[f]);
    end
    chk_eq("interp_addr", int'(addr), 22);
    halt();

    // pause mid-hold, resume at held address and phase
    go(2'b01, 3, 0, 0, 30, 60);
    for (int f = 0; f < 5; f++) begin
      chk_eq("pause_pre_addr", int'(addr), a4[f]);
      frame();
      chk_eq("pause_pre_dat", int'(dac), d4[f]);
    end
    pause = 1'b1;
    @(negedge clk);
    pause = 1'b0;
    @(negedge clk);
    chk_eq("paused_dac", int'(dac), 0);
    chk_eq("paused_playing", int'(playing), 0);
    repeat (10) frame();
    chk_eq("paused_addr", int'(addr), 31);
    chk_eq("paused_dac_late", int'(dac), 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_eq("resume_playing", int'(playing), 1);
    chk_eq("resume_addr", int'(addr), 31);
    frame();
    chk_eq("resume_dat", int'(dac), -690);
    chk_eq("resume_step_addr", int'(addr), 32);
    frame();
    chk_eq("resume_next_dat", int'(dac), -680);
    halt();

    // stop beats pause in WAIT_HIGH; invalid region ignored
    go(2'b00, 3, 0, 0, 100, 109);
    frame();
    chk_eq("prio_addr", int'(addr), 103);
    daclrck = 1'b1;
    repeat (2) @(negedge clk);
    stop = 1'b1;
    pause = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    pause = 1'b0;
    daclrck = 1'b0;
    @(negedge clk);
    chk_eq("prio_playing", int'(playing), 0);
    go(2'b00, 3, 0, 0, 40, 45);
    chk_eq("prio_restart_addr", int'(addr), 40);
    halt();
    go(2'b00, 3, 0, 0, 50, 40);
    @(negedge clk);
    chk_eq("badregion_playing", int'(playing), 0);
    chk_eq("badregion_addr", int'(addr), 40);

    // reset in the middle of interpolation
    go(2'b10, 4, 0, 0, 20, 30);
    frame();
    frame();
    chk_eq("rstmid_pre_dat", int'(dac), -200);
    rst = 1'b1;
    @(negedge clk);
    chk_eq("rstmid_dac", int'(dac), 0);
    chk_eq("rstmid_addr", int'(addr), 0);
    chk_eq("rstmid_playing", int'(playing), 0);
    chk_eq("rstmid_done", int'(done), 0);
    rst = 1'b0;
    frame();
    chk_eq("rstmid_idle_dac", int'(dac), 0);
    chk_eq("rstmid_idle_playing", int'(playing), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
